// File: rtl/yuv420_unpack_pkg.sv
// Shared stream type codes, FSM states and the chroma offset helper for the
// YUV/raw word unpacker.
package yuv420_unpack_pkg;

  localparam int DTYPE_WIDTH = 4;

  localparam logic [3:0] DTYPE_FRAME_START  = 4'h1;
  localparam logic [3:0] DTYPE_FRAME_END    = 4'h2;
  localparam logic [3:0] DTYPE_ROW_START    = 4'h3;
  localparam logic [3:0] DTYPE_ROW_END      = 4'h4;
  localparam logic [3:0] DTYPE_HEADER_START = 4'h5;
  localparam logic [3:0] DTYPE_HEADER       = 4'h6;
  localparam logic [3:0] DTYPE_PIXEL        = 4'h8;
  localparam logic [3:0] DTYPE_PIXEL_MASK   = 4'h8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HDR    = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_ENDF   = 2'd3
  } state_t;

  // Adding 128 mod 256 is the same as removing the +128 bias.
  function automatic logic [7:0] unbias(input logic [7:0] b);
    return b + 8'd128;
  endfunction

endpackage

// File: rtl/yuv420_unpack_if.sv
// Word-in / pixel-out stream bundle of the unpacker; slave is the unpacker side.
interface yuv420_unpack_if;
  import yuv420_unpack_pkg::*;

  logic                   dvi;
  logic [DTYPE_WIDTH-1:0] dtypei;
  logic [31:0]            datai;
  logic                   rdyo;
  logic                   dvo;
  logic [DTYPE_WIDTH-1:0] dtypeo;
  logic [7:0]             yo;
  logic [7:0]             uo;
  logic [7:0]             vo;
  logic [15:0]            meta_datao;

  modport slave (
    input  dvi, dtypei, datai,
    output rdyo, dvo, dtypeo, yo, uo, vo, meta_datao
  );

  modport master (
    output dvi, dtypei, datai,
    input  rdyo, dvo, dtypeo, yo, uo, vo, meta_datao
  );

endinterface

// File: rtl/yuv420_byte_fifo.sv
// 8-byte shift buffer: appends a 32b word (byte0 first) and drops 0..3 bytes
// from the head per cycle. Bytes above the fill level are kept at zero.
module yuv420_byte_fifo (
  input  logic        clk,
  input  logic        resetb,
  input  logic        clear,
  input  logic        push,
  input  logic [31:0] push_data,
  input  logic [1:0]  pop,
  output logic [3:0]  fill,
  output logic [31:0] peek
);

  logic [63:0] data_r;
  logic [3:0]  fill_r;
  logic [63:0] shifted_s;
  logic [3:0]  base_s;
  logic [63:0] data_n_s;
  logic [3:0]  fill_n_s;

  // Pop from the head, then append the pushed word just above what remains.
  always_comb begin
    base_s    = fill_r - {2'b00, pop};
    shifted_s = data_r >> {pop, 3'b000};
    data_n_s  = push ? (shifted_s | ({32'd0, push_data} << {base_s, 3'b000})) : shifted_s;
    fill_n_s  = push ? (base_s + 4'd4) : base_s;
  end

  // Storage and fill count.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      data_r <= 64'd0;
      fill_r <= 4'd0;
    end else if (clear) begin
      data_r <= 64'd0;
      fill_r <= 4'd0;
    end else begin
      data_r <= data_n_s;
      fill_r <= fill_n_s;
    end
  end

  assign fill = fill_r;
  assign peek = data_r[31:0];

endmodule

// File: rtl/yuv420_unpack.sv
// Receive-side unpacker: word-packed raw / YUV 4:4:4 / YUV 4:2:0 stream back to
// one pixel per cycle with regenerated row framing and chroma bias removed.
module yuv420_unpack
  import yuv420_unpack_pkg::*;
#(
  parameter int RAW_PIXEL_SHIFT = 0,
  parameter int COLS_WIDTH      = 11,
  parameter int ROWS_WIDTH      = 11
) (
  input  logic                  clk,
  input  logic                  resetb,
  input  logic [15:0]           image_type,
  input  logic                  enable_420,
  input  logic [COLS_WIDTH-1:0] num_cols,
  input  logic [ROWS_WIDTH-1:0] num_rows,
  yuv420_unpack_if.slave        bus,
  output logic                  underflow
);

  state_t                 state_r, state_n;
  logic                   raw_r, raw_n, yuv420_r, yuv420_n;
  logic [COLS_WIDTH-1:0]  cols_r, cols_n, col_r, col_n;
  logic [ROWS_WIDTH-1:0]  rows_r, rows_n, row_r, row_n;
  logic                   row_open_r, row_open_n, row_phase_r, row_phase_n;
  logic                   pair_second_r, pair_second_n;
  logic                   hdr_pend_r, hdr_pend_n, fe_pend_r, fe_pend_n;
  logic [15:0]            hdr_hi_r, hdr_hi_n;
  logic                   underflow_r, underflow_n, rdyo_r, rdyo_n;
  logic                   dvo_r, dvo_n;
  logic [DTYPE_WIDTH-1:0] dtype_r, dtype_n;
  logic [7:0]             y_r, y_n, u_r, u_n, v_r, v_n;
  logic [15:0]            meta_r, meta_n;

  logic        accept_s, is_pix_s, engine_en_s, last_col_s, ready_s;
  logic        push_s, clear_s, pair_next_s;
  logic [1:0]  pop_s, take_s;
  logic [2:0]  need_s;
  logic [3:0]  fill_s, fill_n_s;
  logic [31:0] peek_s;
  logic [7:0]  py_s, pu_s, pv_s;
  logic [15:0] pmeta_s;

  assign accept_s   = bus.dvi && rdyo_r;
  assign is_pix_s   = (bus.dtypei & DTYPE_PIXEL_MASK) != 4'd0;
  assign last_col_s = (col_r + COLS_WIDTH'(1)) == cols_r;

  yuv420_byte_fifo u_fifo (
    .clk       (clk),
    .resetb    (resetb),
    .clear     (clear_s),
    .push      (push_s),
    .push_data (bus.datai),
    .pop       (pop_s),
    .fill      (fill_s),
    .peek      (peek_s)
  );

  // Decode the pixel at the buffer head for the current mode and row parity.
  always_comb begin
    py_s        = peek_s[7:0];
    pu_s        = 8'd0;
    pv_s        = 8'd0;
    pmeta_s     = 16'd0;
    need_s      = 3'd1;
    take_s      = 2'd1;
    pair_next_s = 1'b0;
    if (raw_r) begin
      py_s    = 8'd0;
      pmeta_s = {8'd0, peek_s[7:0]} << RAW_PIXEL_SHIFT;
    end else if (!yuv420_r || pair_second_r) begin
      pu_s   = unbias(peek_s[15:8]);
      pv_s   = unbias(peek_s[23:16]);
      need_s = 3'd3;
      take_s = 2'd3;
    end else if (!row_phase_r || last_col_s) begin
      need_s = 3'd1;
    end else begin
      // First of an odd-row pair: U,V sit behind Y1 and stay for the second pixel.
      pu_s        = unbias(peek_s[23:16]);
      pv_s        = unbias(peek_s[31:24]);
      need_s      = 3'd4;
      pair_next_s = 1'b1;
    end
    ready_s = fill_s >= {1'b0, need_s};
  end

  // Input word handling, output engine and next-state selection.
  always_comb begin
    state_n = state_r;     raw_n = raw_r;          yuv420_n = yuv420_r;
    cols_n = cols_r;       rows_n = rows_r;        col_n = col_r;   row_n = row_r;
    row_open_n = row_open_r;  row_phase_n = row_phase_r;  pair_second_n = pair_second_r;
    hdr_pend_n = hdr_pend_r;  hdr_hi_n = hdr_hi_r;  fe_pend_n = fe_pend_r;
    underflow_n = underflow_r;
    dvo_n = 1'b0;  dtype_n = 4'd0;  y_n = 8'd0;  u_n = 8'd0;  v_n = 8'd0;  meta_n = 16'd0;
    pop_s = 2'd0;  push_s = 1'b0;  clear_s = 1'b0;  engine_en_s = 1'b1;

    if (hdr_pend_r) begin
      dvo_n = 1'b1;  dtype_n = DTYPE_HEADER;  meta_n = hdr_hi_r;
      hdr_pend_n = 1'b0;  engine_en_s = 1'b0;
    end else if (accept_s) begin
      case (bus.dtypei)
        DTYPE_FRAME_START: begin
          dvo_n = 1'b1;  dtype_n = DTYPE_FRAME_START;  clear_s = 1'b1;  engine_en_s = 1'b0;
          raw_n = image_type == 16'd0;  yuv420_n = enable_420;
          cols_n = num_cols;  rows_n = num_rows;
          col_n = '0;  row_n = '0;  row_open_n = 1'b0;  row_phase_n = 1'b0;
          pair_second_n = 1'b0;  fe_pend_n = 1'b0;
          underflow_n = state_r == ST_ACTIVE;
          state_n = ST_HDR;
        end
        DTYPE_HEADER_START: begin
          dvo_n = 1'b1;  dtype_n = DTYPE_HEADER_START;  engine_en_s = 1'b0;
        end
        DTYPE_HEADER: begin
          dvo_n = 1'b1;  dtype_n = DTYPE_HEADER;  meta_n = bus.datai[15:0];
          hdr_pend_n = 1'b1;  hdr_hi_n = bus.datai[31:16];  engine_en_s = 1'b0;
        end
        DTYPE_FRAME_END: fe_pend_n = 1'b1;
        DTYPE_ROW_START: state_n = (state_r == ST_HDR) ? ST_ACTIVE : state_r;
        DTYPE_ROW_END:   state_n = state_r;
        default: begin
          if (is_pix_s && (state_r == ST_HDR || state_r == ST_ACTIVE)) begin
            push_s  = 1'b1;
            state_n = ST_ACTIVE;
          end else begin
            push_s  = 1'b0;
          end
        end
      endcase
    end else begin
      engine_en_s = 1'b1;
    end

    if (engine_en_s) begin
      case (state_r)
        ST_IDLE: begin
          if (fe_pend_r) begin
            dvo_n = 1'b1;  dtype_n = DTYPE_FRAME_END;  fe_pend_n = 1'b0;
          end else begin
            dvo_n = 1'b0;
          end
        end
        ST_HDR: begin
          if (fe_pend_r) begin
            dvo_n = 1'b1;  dtype_n = DTYPE_FRAME_END;  fe_pend_n = 1'b0;
            underflow_n = (cols_r != '0) && (rows_r != '0);
            clear_s = 1'b1;  state_n = ST_IDLE;
          end else begin
            dvo_n = 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (row_r == rows_r) begin
            clear_s = 1'b1;  state_n = ST_ENDF;
          end else if (row_open_r && col_r == cols_r) begin
            dvo_n = 1'b1;  dtype_n = DTYPE_ROW_END;
            row_open_n = 1'b0;  col_n = '0;  row_n = row_r + ROWS_WIDTH'(1);
            row_phase_n = !row_phase_r;  pair_second_n = 1'b0;
            if ((row_r + ROWS_WIDTH'(1)) == rows_r) begin
              clear_s = 1'b1;  state_n = ST_ENDF;
            end else begin
              clear_s = 1'b0;
            end
          end else if (ready_s && row_open_r) begin
            dvo_n = 1'b1;  dtype_n = DTYPE_PIXEL;
            y_n = py_s;  u_n = pu_s;  v_n = pv_s;  meta_n = pmeta_s;
            pop_s = take_s;  pair_second_n = pair_next_s;  col_n = col_r + COLS_WIDTH'(1);
          end else if (!row_open_r && (ready_s || !fe_pend_r)) begin
            dvo_n = 1'b1;  dtype_n = DTYPE_ROW_START;  row_open_n = 1'b1;
          end else if (fe_pend_r && row_open_r) begin
            dvo_n = 1'b1;  dtype_n = DTYPE_ROW_END;  row_open_n = 1'b0;
          end else if (fe_pend_r) begin
            dvo_n = 1'b1;  dtype_n = DTYPE_FRAME_END;  fe_pend_n = 1'b0;
            underflow_n = 1'b1;  clear_s = 1'b1;  state_n = ST_IDLE;
          end else begin
            dvo_n = 1'b0;
          end
        end
        ST_ENDF: begin
          clear_s = 1'b1;
          if (fe_pend_r) begin
            dvo_n = 1'b1;  dtype_n = DTYPE_FRAME_END;  fe_pend_n = 1'b0;  state_n = ST_IDLE;
          end else begin
            dvo_n = 1'b0;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end else begin
      clear_s = clear_s;
    end

    fill_n_s = clear_s ? 4'd0 : (fill_s - {2'b00, pop_s} + (push_s ? 4'd4 : 4'd0));
    rdyo_n   = (fill_n_s <= 4'd4) && !hdr_pend_n && !fe_pend_n;
  end

  // State, mode and output registers.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_r <= ST_IDLE;  raw_r <= 1'b0;  yuv420_r <= 1'b0;
      cols_r <= '0;  rows_r <= '0;  col_r <= '0;  row_r <= '0;
      row_open_r <= 1'b0;  row_phase_r <= 1'b0;  pair_second_r <= 1'b0;
      hdr_pend_r <= 1'b0;  hdr_hi_r <= 16'd0;  fe_pend_r <= 1'b0;
      underflow_r <= 1'b0;  rdyo_r <= 1'b1;
      dvo_r <= 1'b0;  dtype_r <= 4'd0;  y_r <= 8'd0;  u_r <= 8'd0;  v_r <= 8'd0;  meta_r <= 16'd0;
    end else begin
      state_r <= state_n;  raw_r <= raw_n;  yuv420_r <= yuv420_n;
      cols_r <= cols_n;  rows_r <= rows_n;  col_r <= col_n;  row_r <= row_n;
      row_open_r <= row_open_n;  row_phase_r <= row_phase_n;  pair_second_r <= pair_second_n;
      hdr_pend_r <= hdr_pend_n;  hdr_hi_r <= hdr_hi_n;  fe_pend_r <= fe_pend_n;
      underflow_r <= underflow_n;  rdyo_r <= rdyo_n;
      dvo_r <= dvo_n;  dtype_r <= dtype_n;  y_r <= y_n;  u_r <= u_n;  v_r <= v_n;  meta_r <= meta_n;
    end
  end

  assign bus.rdyo       = rdyo_r;
  assign bus.dvo        = dvo_r;
  assign bus.dtypeo     = dtype_r;
  assign bus.yo         = y_r;
  assign bus.uo         = u_r;
  assign bus.vo         = v_r;
  assign bus.meta_datao = meta_r;
  assign underflow      = underflow_r;

endmodule

// File: tb/tb_yuv420_unpack.sv
// Scoreboard bench for yuv420_unpack: expected entries queued with the stimulus,
// popped and compared whenever the unpacker presents an output.
module tb_yuv420_unpack;
  import yuv420_unpack_pkg::*;

  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic [15:0] image_type = 16'd0;
  logic        enable_420 = 1'b0;
  logic [10:0] num_cols = 11'd0;
  logic [10:0] num_rows = 11'd0;
  logic        underflow;

  yuv420_unpack_if bus ();

  yuv420_unpack #(.RAW_PIXEL_SHIFT(0), .COLS_WIDTH(11), .ROWS_WIDTH(11)) dut (
    .clk        (clk),
    .resetb     (resetb),
    .image_type (image_type),
    .enable_420 (enable_420),
    .num_cols   (num_cols),
    .num_rows   (num_rows),
    .bus        (bus.slave),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          stall_cycles = 0;
  logic [43:0] sb[$];
  logic [43:0] got_e, exp_e;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic expect_e(input logic [3:0] dt, input logic [7:0] y, input logic [7:0] u,
                          input logic [7:0] v, input logic [15:0] meta);
    sb.push_back({dt, y, u, v, meta});
  endtask

  task automatic expect_ctl(input logic [3:0] dt);
    expect_e(dt, 8'd0, 8'd0, 8'd0, 16'd0);
  endtask

  // Drive one word and hold it until the unpacker takes it.
  task automatic send(input logic [3:0] dt, input logic [31:0] d);
    bit acc = 1'b0;
    int n = 0;
    bus.dvi = 1'b1;  bus.dtypei = dt;  bus.datai = d;
    while (!acc && n < 200) begin
      acc = bus.rdyo;
      @(posedge clk);
      n++;
      #1;
    end
    if (!acc) check_eq("send_timeout", 64'(n), 64'd0);
    bus.dvi = 1'b0;
  endtask

  task automatic send_hdr(input logic [31:0] d);
    send(DTYPE_HEADER, d);
    @(negedge clk);
    check_eq("hdr_rdyo_low", 64'(bus.rdyo), 64'd0);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check_eq("drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic config_frame(input logic [15:0] it, input logic e420,
                              input logic [10:0] cols, input logic [10:0] rows);
    image_type = it;  enable_420 = e420;  num_cols = cols;  num_rows = rows;
  endtask

  task automatic expect_raw_rows(input int cols, input int rows, input int first);
    for (int r = 0; r < rows; r++) begin
      expect_ctl(DTYPE_ROW_START);
      for (int c = 0; c < cols; c++) expect_e(DTYPE_PIXEL, 8'd0, 8'd0, 8'd0, 16'(first + r * cols + c));
      expect_ctl(DTYPE_ROW_END);
    end
  endtask

  task automatic raw_4x2(input bit with_hdr);
    config_frame(16'd0, 1'b0, 11'd4, 11'd2);
    expect_ctl(DTYPE_FRAME_START);
    if (with_hdr) begin
      expect_ctl(DTYPE_HEADER_START);
      expect_e(DTYPE_HEADER, 8'd0, 8'd0, 8'd0, 16'hAAAA);
      expect_e(DTYPE_HEADER, 8'd0, 8'd0, 8'd0, 16'hBBBB);
      expect_e(DTYPE_HEADER, 8'd0, 8'd0, 8'd0, 16'hCCCC);
      expect_e(DTYPE_HEADER, 8'd0, 8'd0, 8'd0, 16'hDDDD);
    end
    expect_raw_rows(4, 2, 0);
    expect_ctl(DTYPE_FRAME_END);
    send(DTYPE_FRAME_START, 32'd0);
    if (with_hdr) begin
      send(DTYPE_HEADER_START, 32'd0);
      send_hdr(32'hBBBB_AAAA);
      send_hdr(32'hDDDD_CCCC);
    end
    send(DTYPE_PIXEL, 32'h0302_0100);
    send(DTYPE_PIXEL, 32'h0706_0504);
    send(DTYPE_FRAME_END, 32'd0);
    drain();
    check_eq("raw_underflow", 64'(underflow), 64'd0);
  endtask

  // Output monitor and stall counter, sampled away from the active edge.
  always @(negedge clk) begin
    if (resetb && bus.dvo) begin
      got_e = {bus.dtypeo, bus.yo, bus.uo, bus.vo, bus.meta_datao};
      if (sb.size() == 0) begin
        check_eq("extra_output", 64'(got_e), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_e = sb.pop_front();
        check_eq("output", 64'(got_e), 64'(exp_e));
      end
    end
    if (resetb && bus.dvi && !bus.rdyo) stall_cycles++;
  end

  initial begin
    bus.dvi = 1'b0;  bus.dtypei = 4'd0;  bus.datai = 32'd0;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", 64'({bus.dvo, bus.dtypeo, bus.yo, bus.uo, bus.vo, bus.meta_datao}), 64'd0);
    check_eq("reset_rdyo", 64'(bus.rdyo), 64'd1);
    check_eq("reset_underflow", 64'(underflow), 64'd0);
    resetb = 1'b1;

    raw_4x2(1'b1);

    // 4:4:4 3x1: Y,U,V = 10,128,130 three times, then three pad bytes.
    config_frame(16'd1, 1'b0, 11'd3, 11'd1);
    expect_ctl(DTYPE_FRAME_START);
    expect_ctl(DTYPE_ROW_START);
    for (int i = 0; i < 3; i++) expect_e(DTYPE_PIXEL, 8'd10, 8'd0, 8'd2, 16'd0);
    expect_ctl(DTYPE_ROW_END);
    expect_ctl(DTYPE_FRAME_END);
    send(DTYPE_FRAME_START, 32'd0);
    send(DTYPE_PIXEL, 32'h0A82_800A);
    send(DTYPE_PIXEL, 32'h800A_8280);
    send(DTYPE_PIXEL, 32'hEEEE_EE82);
    send(DTYPE_FRAME_END, 32'd0);
    drain();

    // 4:2:0 4x2: luma-only even row, Y0 Y1 U V pairs on the odd row.
    config_frame(16'd1, 1'b1, 11'd4, 11'd2);
    expect_ctl(DTYPE_FRAME_START);
    expect_ctl(DTYPE_ROW_START);
    for (int i = 1; i <= 4; i++) expect_e(DTYPE_PIXEL, 8'(i), 8'd0, 8'd0, 16'd0);
    expect_ctl(DTYPE_ROW_END);
    expect_ctl(DTYPE_ROW_START);
    expect_e(DTYPE_PIXEL, 8'd5, 8'd10, 8'hF6, 16'd0);
    expect_e(DTYPE_PIXEL, 8'd6, 8'd10, 8'hF6, 16'd0);
    expect_e(DTYPE_PIXEL, 8'd7, 8'd1, 8'hFF, 16'd0);
    expect_e(DTYPE_PIXEL, 8'd8, 8'd1, 8'hFF, 16'd0);
    expect_ctl(DTYPE_ROW_END);
    expect_ctl(DTYPE_FRAME_END);
    send(DTYPE_FRAME_START, 32'd0);
    send(DTYPE_ROW_START, 32'd0);
    send(DTYPE_PIXEL, 32'h0403_0201);
    send(DTYPE_ROW_END, 32'd0);
    send(DTYPE_PIXEL, 32'h768A_0605);
    send(DTYPE_PIXEL, 32'h7F81_0807);
    send(DTYPE_FRAME_END, 32'd0);
    drain();
    check_eq("yuv420_underflow", 64'(underflow), 64'd0);

    // Truncated raw 6x2 frame: only 8 of 12 pixels arrive before FRAME_END.
    config_frame(16'd0, 1'b0, 11'd6, 11'd2);
    expect_ctl(DTYPE_FRAME_START);
    expect_raw_rows(6, 1, 16);
    expect_ctl(DTYPE_ROW_START);
    expect_e(DTYPE_PIXEL, 8'd0, 8'd0, 8'd0, 16'h16);
    expect_e(DTYPE_PIXEL, 8'd0, 8'd0, 8'd0, 16'h17);
    expect_ctl(DTYPE_ROW_END);
    expect_ctl(DTYPE_FRAME_END);
    send(DTYPE_FRAME_START, 32'd0);
    send(DTYPE_PIXEL, 32'h1312_1110);
    send(DTYPE_PIXEL, 32'h1716_1514);
    send(DTYPE_FRAME_END, 32'd0);
    drain();
    check_eq("trunc_underflow", 64'(underflow), 64'd1);

    // Backpressure: raw 16x2 streamed back to back.
    config_frame(16'd0, 1'b0, 11'd16, 11'd2);
    expect_ctl(DTYPE_FRAME_START);
    expect_raw_rows(16, 2, 32);
    expect_ctl(DTYPE_FRAME_END);
    send(DTYPE_FRAME_START, 32'd0);
    check_eq("fs_clears_underflow", 64'(underflow), 64'd0);
    stall_cycles = 0;
    for (int w = 0; w < 8; w++) begin
      logic [31:0] d;
      for (int b = 0; b < 4; b++) d[8*b +: 8] = 8'(32 + 4 * w + b);
      send(DTYPE_PIXEL, d);
    end
    send(DTYPE_FRAME_END, 32'd0);
    drain();
    check_eq("backpressure_seen", 64'(stall_cycles != 0), 64'd1);
    check_eq("bp_underflow", 64'(underflow), 64'd0);

    // Reset in the middle of a row, then a clean frame.
    config_frame(16'd0, 1'b0, 11'd4, 11'd2);
    expect_ctl(DTYPE_FRAME_START);
    expect_raw_rows(4, 2, 0);
    send(DTYPE_FRAME_START, 32'd0);
    send(DTYPE_PIXEL, 32'h0302_0100);
    repeat (2) @(posedge clk);
    #2;
    resetb = 1'b0;
    sb.delete();
    #1;
    check_eq("midreset_outputs", 64'({bus.dvo, bus.dtypeo, bus.yo, bus.uo, bus.vo, bus.meta_datao}), 64'd0);
    check_eq("midreset_rdyo", 64'(bus.rdyo), 64'd1);
    repeat (2) @(negedge clk);
    resetb = 1'b1;
    raw_4x2(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
